// File: rtl/cpu_press_ctrl_pkg.sv
// Shared types and widths for the computer-player key-press sequencer.
package cpu_press_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, PRESS, COOLDOWN} cpu_state_t;

  localparam int LFSR_W = 10;
  localparam int DIFF_W = 9;

endpackage

// File: rtl/cpu_press_ctrl_if.sv
// Bundle between the difficulty switches / game logic and the press sequencer.
interface cpu_press_ctrl_if;
  import cpu_press_pkg::*;

  logic              enable;
  logic [DIFF_W-1:0] difficulty;
  logic              press;
  logic              cooling;
  logic [LFSR_W-1:0] lfsr_value;

  modport master (
    output enable,
    output difficulty,
    input  press,
    input  cooling,
    input  lfsr_value
  );

  modport slave (
    input  enable,
    input  difficulty,
    output press,
    output cooling,
    output lfsr_value
  );

endinterface

// File: rtl/cpu_press_ctrl_lfsr10.sv
// 10-bit XNOR LFSR (taps 10 and 7); all-ones is the lock-up state and is
// unreachable from the all-zero reset value.
module lfsr10 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  output logic [9:0] q
);

  logic [9:0] q_reg;
  logic [9:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (step) begin
      q_next = {q_reg[8:0], ~(q_reg[9] ^ q_reg[6])};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/cpu_press_ctrl.sv
// Paces random-vs-difficulty decisions on a tick, emits one-cycle presses and
// holds off further presses for a tick-based cooldown.
module cpu_press_ctrl
  import cpu_press_pkg::*;
#(
  parameter int TICK_DIV       = 4,
  parameter int COOLDOWN_TICKS = 2,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cpu_press_ctrl_if.slave      bus
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  CD_LOAD   = CNT_W'(COOLDOWN_TICKS);

  logic [TICK_W-1:0] tick_cnt_reg;
  logic [TICK_W-1:0] tick_cnt_next;
  logic              tick;

  cpu_state_t        state_reg;
  cpu_state_t        state_next;
  logic [CNT_W-1:0]  cd_cnt_reg;
  logic [CNT_W-1:0]  cd_cnt_next;
  logic              press_reg;
  logic              cooling_reg;

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_step;
  logic              hit;

  // Counter is parked at zero while disabled so the first tick lands on the
  // TICK_DIV-th enabled cycle.
  assign tick = bus.enable && (tick_cnt_reg == TICK_LAST);

  always_comb begin
    tick_cnt_next = '0;
    if (bus.enable && !tick) begin
      tick_cnt_next = tick_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_next;
    end
  end

  assign lfsr_step = tick && (state_reg != IDLE);

  lfsr10 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (lfsr_step),
    .q       (lfsr_q)
  );

  // Compare uses the value before this tick's shift; equality is not a hit.
  assign hit = ({bus.difficulty, 1'b0} > lfsr_q);

  always_comb begin
    state_next  = state_reg;
    cd_cnt_next = cd_cnt_reg;
    if (!bus.enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: state_next = WAIT;
        WAIT: begin
          if (tick && hit) begin
            state_next = PRESS;
          end
        end
        PRESS: begin
          state_next  = COOLDOWN;
          cd_cnt_next = CD_LOAD;
        end
        COOLDOWN: begin
          if (tick) begin
            if (cd_cnt_reg == '0) begin
              state_next = WAIT;
            end else begin
              cd_cnt_next = cd_cnt_reg - 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track state_reg exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cd_cnt_reg  <= '0;
      press_reg   <= 1'b0;
      cooling_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cd_cnt_reg  <= cd_cnt_next;
      press_reg   <= (state_next == PRESS);
      cooling_reg <= (state_next == COOLDOWN);
    end
  end

  assign bus.press      = press_reg;
  assign bus.cooling    = cooling_reg;
  assign bus.lfsr_value = lfsr_q;

endmodule

// File: tb/tb_cpu_press_ctrl.sv
// Scoreboard bench for cpu_press_ctrl: a cycle model queues expected outputs,
// plus scenario checks against hand-derived constants.
module tb_cpu_press_ctrl;

  localparam int TICK_DIV       = 4;
  localparam int COOLDOWN_TICKS = 2;
  localparam int CNT_W          = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  cpu_press_ctrl_if bus ();

  cpu_press_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .COOLDOWN_TICKS (COOLDOWN_TICKS),
    .CNT_W          (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       press;
    logic       cooling;
    logic [9:0] lfsr;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         m_cnt, m_state, m_cd;
  logic [9:0] m_lfsr;
  logic       prev_press;
  logic [9:0] pre_lfsr;

  task automatic model_reset();
    m_cnt   = 0;
    m_state = 0;
    m_cd    = 0;
    m_lfsr  = 10'h000;
    sb_q.delete();
  endtask

  // Behavioural reference: states 0=idle 1=wait 2=press 3=cooldown.
  task automatic model_step(input logic en, input logic [8:0] diff);
    logic tick;
    logic hit;
    int   ns;
    exp_t e;
    tick = en && (m_cnt == TICK_DIV - 1);
    hit  = ({diff, 1'b0} > m_lfsr);
    ns   = m_state;
    if (!en) ns = 0;
    else begin
      case (m_state)
        0: ns = 1;
        1: if (tick && hit) ns = 2;
        2: begin ns = 3; m_cd = COOLDOWN_TICKS; end
        default: if (tick) begin
          if (m_cd == 0) ns = 1;
          else m_cd = m_cd - 1;
        end
      endcase
    end
    if (tick && m_state != 0) m_lfsr = {m_lfsr[8:0], ~(m_lfsr[9] ^ m_lfsr[6])};
    m_cnt   = (!en || tick) ? 0 : m_cnt + 1;
    m_state = ns;
    e.press   = (ns == 2);
    e.cooling = (ns == 3);
    e.lfsr    = m_lfsr;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input logic en, input logic [8:0] diff);
    exp_t e;
    bus.enable     = en;
    bus.difficulty = diff;
    model_step(en, diff);
    pre_lfsr   = bus.lfsr_value;
    prev_press = bus.press;
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    checks++;
    if (bus.press !== e.press) begin
      errors++;
      $display("FAIL sb_press cyc=%0d got=%b exp=%b", cyc, bus.press, e.press);
    end
    checks++;
    if (bus.cooling !== e.cooling) begin
      errors++;
      $display("FAIL sb_cooling cyc=%0d got=%b exp=%b", cyc, bus.cooling, e.cooling);
    end
    checks++;
    if (bus.lfsr_value !== e.lfsr) begin
      errors++;
      $display("FAIL sb_lfsr cyc=%0d got=%03h exp=%03h", cyc, bus.lfsr_value, e.lfsr);
    end
    if (bus.press && !prev_press)
      $display("press rise cyc=%0d lfsr_before=%03h", cyc, pre_lfsr);
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    bus.enable     = 1'b0;
    bus.difficulty = 9'h000;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.press !== 1'b0 || bus.cooling !== 1'b0 || bus.lfsr_value !== 10'h000) begin
      errors++;
      $display("FAIL reset_initial got=%b/%b/%03h exp=0/0/000", bus.press, bus.cooling, bus.lfsr_value);
    end
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (6) cycle(1'b1, 9'h1FF);
    checks++;
    if (bus.cooling !== 1'b1 || bus.lfsr_value !== 10'h001) begin
      errors++;
      $display("FAIL reset_precond got=%b/%03h exp=1/001", bus.cooling, bus.lfsr_value);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.press !== 1'b0 || bus.cooling !== 1'b0 || bus.lfsr_value !== 10'h000) begin
      errors++;
      $display("FAIL reset_async got=%b/%b/%03h exp=0/0/000", bus.press, bus.cooling, bus.lfsr_value);
    end
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_lfsr_seq();
    logic [9:0] tbl [9];
    tbl = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
            10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    apply_reset();
    checks++;
    if (bus.lfsr_value !== tbl[0]) begin
      errors++;
      $display("FAIL lfsr_seq k=0 got=%03h exp=%03h", bus.lfsr_value, tbl[0]);
    end
    for (int k = 1; k < 9; k++) begin
      repeat (4) cycle(1'b1, 9'h000);
      checks++;
      if (bus.lfsr_value !== tbl[k] || bus.press !== 1'b0) begin
        errors++;
        $display("FAIL lfsr_seq k=%0d got=%03h/press=%b exp=%03h/press=0", k, bus.lfsr_value, bus.press, tbl[k]);
      end
    end
  endtask

  task automatic test_max_difficulty();
    int rises[$];
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b1, 9'h1FF);
      if (bus.press && !prev_press) rises.push_back(i);
      checks++;
      if (bus.press && prev_press) begin
        errors++;
        $display("FAIL press_double cyc=%0d got=1 exp=0", i);
      end
      if (i >= 5 && i <= 16) begin
        checks++;
        if (bus.cooling !== (i <= 15)) begin
          errors++;
          $display("FAIL cooling_window i=%0d got=%b exp=%b", i, bus.cooling, (i <= 15));
        end
      end
    end
    checks++;
    if (rises.size() != 3) begin
      errors++;
      $display("FAIL press_count got=%0d exp=3", rises.size());
    end else begin
      checks++;
      if (rises[0] != 4 || rises[1] != 20 || rises[2] != 36) begin
        errors++;
        $display("FAIL press_spacing got=%0d,%0d,%0d exp=4,20,36", rises[0], rises[1], rises[2]);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [9:0] held;
    apply_reset();
    repeat (6) cycle(1'b1, 9'h1FF);
    held = bus.lfsr_value;
    cycle(1'b0, 9'h1FF);
    checks++;
    if (bus.cooling !== 1'b0 || bus.press !== 1'b0 || bus.lfsr_value !== 10'h001) begin
      errors++;
      $display("FAIL enable_drop got=%b/%b/%03h exp=0/0/001", bus.press, bus.cooling, bus.lfsr_value);
    end
    repeat (3) cycle(1'b0, 9'h1FF);
    checks++;
    if (bus.lfsr_value !== held) begin
      errors++;
      $display("FAIL lfsr_hold got=%03h exp=%03h", bus.lfsr_value, held);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 9'h1FF);
      checks++;
      if (bus.press !== (i == 4) || bus.lfsr_value !== ((i == 4) ? 10'h003 : 10'h001)) begin
        errors++;
        $display("FAIL reenable_tick i=%0d got=%b/%03h exp=%b/%03h", i, bus.press, bus.lfsr_value,
                 (i == 4), (i == 4) ? 10'h003 : 10'h001);
      end
    end
  endtask

  task automatic test_threshold();
    bit found = 0;
    apply_reset();
    repeat (32) cycle(1'b1, 9'h000);
    checks++;
    if (bus.lfsr_value !== 10'h0FE) begin
      errors++;
      $display("FAIL thr_precond got=%03h exp=0FE", bus.lfsr_value);
    end
    repeat (4) begin
      cycle(1'b1, 9'h07F);
      checks++;
      if (bus.press !== 1'b0) begin
        errors++;
        $display("FAIL thr_equal got=%b exp=0", bus.press);
      end
    end
    checks++;
    if (bus.lfsr_value !== 10'h1FC) begin
      errors++;
      $display("FAIL thr_step got=%03h exp=1FC", bus.lfsr_value);
    end
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle(1'b1, 9'h07F);
      if (bus.press && !prev_press) begin
        found = 1;
        checks++;
        if (pre_lfsr >= 10'h0FE) begin
          errors++;
          $display("FAIL thr_hit_value got=%03h exp=<0FE", pre_lfsr);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL thr_timeout got=no_press exp=press");
    end
  endtask

  task automatic test_reset_mid_press();
    apply_reset();
    repeat (4) cycle(1'b1, 9'h1FF);
    checks++;
    if (bus.press !== 1'b1) begin
      errors++;
      $display("FAIL midpress_precond got=%b exp=1", bus.press);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.press !== 1'b0 || bus.cooling !== 1'b0 || bus.lfsr_value !== 10'h000) begin
      errors++;
      $display("FAIL midpress_async got=%b/%b/%03h exp=0/0/000", bus.press, bus.cooling, bus.lfsr_value);
    end
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 9'h1FF);
      checks++;
      if (bus.press !== (i == 4)) begin
        errors++;
        $display("FAIL midpress_restart i=%0d got=%b exp=%b", i, bus.press, (i == 4));
      end
    end
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.difficulty = 9'h000;
    model_reset();
    test_reset();
    test_lfsr_seq();
    test_max_difficulty();
    test_enable_drop();
    test_threshold();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
